tlul_gpio: RTL
==============

# tlul_gpio

TL-UL device that implements the GPIO register block in the 24 MHz peripheral domain. It sits directly downstream of the peripheral crossbar on device port 0 and consumes the `tl_h2d_gpio` request stream, returning responses on `tl_d2h_gpio`. It drives the pad outputs and output-enables, and samples the pad inputs through a 2-flop synchronizer. It raises a level interrupt on enabled rising or falling input edges.

## Interface
- `NumGpio`, default 32: number of GPIO lines, range 1..32. Register bits at and above `NumGpio` read 0 and ignore writes.
- `clk_i` input 1: 24 MHz peripheral clock.
- `rst_i` input 1: reset, asynchronous and active-high.
- `tl_i` input `tlul_pkg::tl_h2d_t`: request channel A and `d_ready`.
- `tl_o` output `tlul_pkg::tl_d2h_t`: response channel D and `a_ready`.
- `gpio_i` input `NumGpio`: asynchronous pad inputs.
- `gpio_o` output `NumGpio`: pad output values.
- `gpio_oe_o` output `NumGpio`: pad output enables, 1 = drive.
- `intr_o` output 1: level interrupt equal to `|(INTR_STATE & INTR_ENABLE)`.

## Operation
- **Register map**, word offsets, compared on `a_address[4:0]`:
  - 0x00 INTR_STATE: W1C.
  - 0x04 INTR_ENABLE: RW.
  - 0x08 DATA_IN: RO; writes are ignored without error.
  - 0x0C DIRECT_OUT: RW, drives `gpio_o`.
  - 0x10 DIRECT_OE: RW, drives `gpio_oe_o`.
  - 0x14 EN_RISING: RW.
  - 0x18 EN_FALLING: RW.
- **Opcodes:**
  - Get (4) returns AccessAckData (1) with the register value.
  - PutFullData (0) and PutPartialData (1) return AccessAck (0). Only byte lanes with `a_mask[i]=1` are written.
- **Errors:** `d_error=1` when any of the following holds:
  - opcode not in {0,1,4};
  - `a_address[1:0]!=0`;
  - offset > 0x18.
- **Error handling:** an erroring request still gets a response, with `d_data=0` and no register change. The opcode rules above still apply: AccessAckData for Get, AccessAck otherwise.
- **Response fields:** `d_source` and `d_size` echo the accepted `a_source` and `a_size`. `d_param=0`.
- **Input path:** `gpio_i` passes through 2 flops to give `sync`, and a third flop holds `sync_q`.
  - DATA_IN = `sync`.
  - rise = `sync & ~sync_q & EN_RISING`.
  - fall = `~sync & sync_q & EN_FALLING`.
  - INTR_STATE next = `(INTR_STATE & ~w1c_clear) | rise | fall`.
- **Simultaneous events:** a hardware set and a W1C clear of the same bit in the same cycle leave the bit set. A Get of INTR_STATE returns the pre-update value.
- **Response buffering:** a single response register; at most one outstanding transaction.

## Timing
- **Handshakes:**
  - `a_ready = ~d_valid_q`.
  - A request is accepted when `a_valid & a_ready`.
  - The register write takes effect at that clock edge.
  - `d_valid` asserts on the next cycle. Accept-to-response latency is 1 cycle.
- **Response hold:** `d_valid` and all D fields hold stable until `d_valid & d_ready`. `d_valid` deasserts the cycle after the handshake. A new request can be accepted the cycle after `d_valid` drops, so throughput is at most 1 transaction per 2 cycles.
- **Input latency:** a pad edge appears in DATA_IN 2 cycles after the first sampling edge. INTR_STATE sets 1 cycle after that. `intr_o` is combinational from the registers, so it rises in the same cycle INTR_STATE sets.
- **Write-to-pad latency:** a write to DIRECT_OUT or DIRECT_OE is visible on the pad 1 cycle after acceptance.
- **Reset values:** all registers, synchronizer flops, `gpio_o`, `gpio_oe_o`, `intr_o`, `d_valid` and all D fields are 0; `a_ready=1`.
- **Reset mid-transaction:** asserting `rst_i` while `d_valid=1` drops the pending response immediately (asynchronously). No response is issued after reset deasserts.
- **Edge suppression after reset:** the synchronizer resets to 0. A pad held high through reset therefore produces one rising edge after release. That edge sets INTR_STATE only if EN_RISING was written first. Since EN_RISING resets to 0, no interrupt results.

## Test plan
- PutFullData 0x0C data 0xA5A5_0000 mask 0xF, then PutFullData 0x10 data 0xFFFF_FFFF -> `gpio_o=0xA5A5_0000` and `gpio_oe_o=0xFFFF_FFFF` 1 cycle after each accept. A Get of 0x0C returns 0xA5A5_0000 with `d_opcode=1`, `d_error=0`.
- PutPartialData 0x0C data 0x1234_5678 mask 0x2 over a 0 register -> register reads 0x0000_5600.
- EN_RISING=0x1, INTR_ENABLE=0x1, drive `gpio_i[0]` 0→1 -> INTR_STATE bit0=1 and `intr_o=1` three cycles after the edge. PutFullData 0x00 data 0x1 -> `intr_o=0` the next cycle.
- Bit0 rising edge lands in the same cycle as a W1C of bit0 -> bit0 stays 1 and `intr_o` stays 1.
- Get 0x1C, Get 0x02, and opcode 5 -> each returns `d_error=1`, `d_data=0`, no register change. The next legal access succeeds.
- Hold `d_ready=0` for 5 cycles with `a_valid=1` -> `a_ready=0` throughout and D fields stable. Assert `rst_i` in cycle 3 -> `d_valid=0` and `a_ready=1` immediately, and all outputs are 0.

Source files
------------

// File: rtl/tlul_gpio.sv
`default_nettype none
// ============================================================================
// Module   : tlul_gpio (with tlul_pkg)
// Brief    : TL-UL GPIO register block with synchronized inputs and edge IRQs.
// Revision : 1.0
// ============================================================================

package tlul_pkg;
   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

module tlul_gpio #(
   parameter int NumGpio = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  tlul_pkg::tl_h2d_t  tl_i,
   output tlul_pkg::tl_d2h_t  tl_o,
   input  logic [NumGpio-1:0] gpio_i,
   output logic [NumGpio-1:0] gpio_o,
   output logic [NumGpio-1:0] gpio_oe_o,
   output logic               intr_o
);

   localparam logic [2:0] c_op_put_full    = 3'd0;
   localparam logic [2:0] c_op_put_partial = 3'd1;
   localparam logic [2:0] c_op_get         = 3'd4;
   localparam logic [2:0] c_access_ack     = 3'd0;
   localparam logic [2:0] c_access_ack_dat = 3'd1;

   localparam logic [4:0] c_addr_intr_state = 5'h00;
   localparam logic [4:0] c_addr_intr_en    = 5'h04;
   localparam logic [4:0] c_addr_data_in    = 5'h08;
   localparam logic [4:0] c_addr_direct_out = 5'h0C;
   localparam logic [4:0] c_addr_direct_oe  = 5'h10;
   localparam logic [4:0] c_addr_en_rising  = 5'h14;
   localparam logic [4:0] c_addr_en_falling = 5'h18;

   logic [NumGpio-1:0] r_sync1, r_sync, r_sync_q;
   logic [NumGpio-1:0] r_intr_state, r_intr_enable, r_direct_out, r_direct_oe;
   logic [NumGpio-1:0] r_en_rising, r_en_falling;

   logic        r_d_valid;
   logic [2:0]  r_d_opcode;
   logic [1:0]  r_d_size;
   logic [7:0]  r_d_source;
   logic [31:0] r_d_data;
   logic        r_d_error;

   logic               w_accept, w_is_get, w_is_put, w_err, w_we;
   logic [4:0]         w_addr;
   logic [31:0]        w_bm, w_rdata;
   logic [NumGpio-1:0] w_rise, w_fall, w_clr;
   logic               w_unused;

   function automatic logic [NumGpio-1:0] f_merge(input logic [NumGpio-1:0] old,
                                                  input logic [31:0] bm,
                                                  input logic [31:0] wd);
      return NumGpio'((32'(old) & ~bm) | (wd & bm));
   endfunction

   assign w_addr   = tl_i.a_address[4:0];
   assign w_accept = tl_i.a_valid & ~r_d_valid;
   assign w_is_get = (tl_i.a_opcode == c_op_get);
   assign w_is_put = (tl_i.a_opcode == c_op_put_full) | (tl_i.a_opcode == c_op_put_partial);
   assign w_err    = ~(w_is_get | w_is_put) | (w_addr[1:0] != 2'b00) | (w_addr > c_addr_en_falling);
   assign w_we     = w_accept & w_is_put & ~w_err;
   assign w_bm     = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                      {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};
   assign w_unused = ^{tl_i.a_param, tl_i.a_address[31:5]};

   assign w_rise = r_sync & ~r_sync_q & r_en_rising;
   assign w_fall = ~r_sync & r_sync_q & r_en_falling;
   assign w_clr  = (w_we && w_addr == c_addr_intr_state) ? NumGpio'(tl_i.a_data & w_bm) : '0;

   always_comb begin
      w_rdata = '0;
      case (w_addr)
         c_addr_intr_state: w_rdata = 32'(r_intr_state);
         c_addr_intr_en:    w_rdata = 32'(r_intr_enable);
         c_addr_data_in:    w_rdata = 32'(r_sync);
         c_addr_direct_out: w_rdata = 32'(r_direct_out);
         c_addr_direct_oe:  w_rdata = 32'(r_direct_oe);
         c_addr_en_rising:  w_rdata = 32'(r_en_rising);
         c_addr_en_falling: w_rdata = 32'(r_en_falling);
         default:           w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync1       <= '0;
         r_sync        <= '0;
         r_sync_q      <= '0;
         r_intr_state  <= '0;
         r_intr_enable <= '0;
         r_direct_out  <= '0;
         r_direct_oe   <= '0;
         r_en_rising   <= '0;
         r_en_falling  <= '0;
      end else begin
         r_sync1  <= gpio_i;
         r_sync   <= r_sync1;
         r_sync_q <= r_sync;
         // Hardware set is OR-ed after the clear so a coincident edge wins.
         r_intr_state <= (r_intr_state & ~w_clr) | w_rise | w_fall;
         if (w_we && w_addr == c_addr_intr_en)    r_intr_enable <= f_merge(r_intr_enable, w_bm, tl_i.a_data);
         if (w_we && w_addr == c_addr_direct_out) r_direct_out  <= f_merge(r_direct_out, w_bm, tl_i.a_data);
         if (w_we && w_addr == c_addr_direct_oe)  r_direct_oe   <= f_merge(r_direct_oe, w_bm, tl_i.a_data);
         if (w_we && w_addr == c_addr_en_rising)  r_en_rising   <= f_merge(r_en_rising, w_bm, tl_i.a_data);
         if (w_we && w_addr == c_addr_en_falling) r_en_falling  <= f_merge(r_en_falling, w_bm, tl_i.a_data);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_d_valid  <= 1'b0;
         r_d_opcode <= '0;
         r_d_size   <= '0;
         r_d_source <= '0;
         r_d_data   <= '0;
         r_d_error  <= 1'b0;
      end else if (w_accept) begin
         r_d_valid  <= 1'b1;
         r_d_opcode <= w_is_get ? c_access_ack_dat : c_access_ack;
         r_d_size   <= tl_i.a_size;
         r_d_source <= tl_i.a_source;
         r_d_data   <= (w_is_get && !w_err) ? w_rdata : '0;
         r_d_error  <= w_err;
      end else if (r_d_valid && tl_i.d_ready) begin
         r_d_valid <= 1'b0;
      end
   end

   assign tl_o.d_valid  = r_d_valid;
   assign tl_o.d_opcode = r_d_opcode;
   assign tl_o.d_param  = '0;
   assign tl_o.d_size   = r_d_size;
   assign tl_o.d_source = r_d_source;
   assign tl_o.d_sink   = 1'b0;
   assign tl_o.d_data   = r_d_data;
   assign tl_o.d_error  = r_d_error;
   assign tl_o.a_ready  = ~r_d_valid;

   assign gpio_o    = r_direct_out;
   assign gpio_oe_o = r_direct_oe;
   assign intr_o    = |(r_intr_state & r_intr_enable);

endmodule
`default_nettype wire
